// File: rtl/motor_ramp_pkg.sv
// rtl/motor_ramp_pkg.sv - shared state encoding and timer mode constants for the motor ramp controller
package motor_ramp_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEL  = 2'd1;
    localparam logic [1:0] ST_CRUISE = 2'd2;
    localparam logic [1:0] ST_DECEL  = 2'd3;

    // Timer control encodings, shared with the timer-side integration.
    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_PWM = 2'b10;

endpackage

// File: rtl/motor_ramp_ctrl_tick_gen.sv
// rtl/motor_ramp_ctrl_tick_gen.sv - ramp tick divider, one tick every div+1 enabled cycles
module ramp_tick_gen #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] count_q, count_d;

    // A clear always wins, so a tick can never coincide with a restart of the period.
    assign tick = en && !clear && (count_q == div);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - soft-start/soft-stop PWM compare profile generator with emergency stop
module motor_ramp_ctrl
    import motor_ramp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         estop,
    input  logic [W-1:0] target_duty,
    input  logic [W-1:0] step,
    input  logic [W-1:0] ramp_div,
    output logic [W-1:0] compare,
    output logic [1:0]   control,
    output logic         busy,
    output logic         done,
    output logic         aborted
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] compare_q, compare_d;
    logic [1:0]   control_q, control_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         aborted_q, aborted_d;
    logic [W-1:0] target_l_q, target_l_d;
    logic [W-1:0] step_l_q, step_l_d;
    logic [W-1:0] div_l_q, div_l_d;

    logic         tick;
    logic         div_clear;
    logic         div_en;
    logic         start_ok;
    logic [W:0]   sum_wide;
    logic         sum_reaches_target;

    assign div_en   = (state_q == ST_ACCEL) || (state_q == ST_DECEL);
    assign start_ok = start && !stop && !estop
                      && (target_duty != '0) && (step != '0);

    // One extra bit keeps compare+step from wrapping near the top of the range.
    assign sum_wide           = {1'b0, compare_q} + {1'b0, step_l_q};
    assign sum_reaches_target = (sum_wide >= {1'b0, target_l_q});

    ramp_tick_gen #(
        .W (W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .en    (div_en),
        .div   (div_l_q),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        compare_d  = compare_q;
        control_d  = control_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        target_l_d = target_l_q;
        step_l_d   = step_l_q;
        div_l_d    = div_l_q;
        div_clear  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start_ok) begin
                target_l_d = target_duty;
                step_l_d   = step;
                div_l_d    = ramp_div;
                div_clear  = 1'b1;
                compare_d  = '0;
                control_d  = MODE_PWM;
                state_d    = ST_ACCEL;
            end
        end else if (estop) begin
            compare_d = '0;
            control_d = MODE_OFF;
            aborted_d = 1'b1;
            state_d   = ST_IDLE;
        end else if (stop && (state_q != ST_DECEL)) begin
            div_clear = 1'b1;
            state_d   = ST_DECEL;
        end else if (tick && (state_q == ST_ACCEL)) begin
            if (sum_reaches_target) begin
                compare_d = target_l_q;
                state_d   = ST_CRUISE;
            end else begin
                compare_d = sum_wide[W-1:0];
            end
        end else if (tick && (state_q == ST_DECEL)) begin
            if (compare_q > step_l_q) begin
                compare_d = compare_q - step_l_q;
            end else begin
                compare_d = '0;
                control_d = MODE_OFF;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            compare_q  <= '0;
            control_q  <= MODE_OFF;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            target_l_q <= '0;
            step_l_q   <= '0;
            div_l_q    <= '0;
        end else begin
            state_q    <= state_d;
            compare_q  <= compare_d;
            control_q  <= control_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            target_l_q <= target_l_d;
            step_l_q   <= step_l_d;
            div_l_q    <= div_l_d;
        end
    end

    assign compare = compare_q;
    assign control = control_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule
